bitstream_decoder: RTL and testbench

Converts a unary stochastic bitstream back to a BITWIDTH-bit binary value by counting ones over a window of 2^k sampled bits. It is the receive end of the Sobol-RNG/comparator encoding path: an encoded stream, or a stream produced by unary arithmetic, enters here, and a scaled binary result leaves through a valid/ready handshake.

---
 rtl/bitstream_decoder_pkg.sv | 22 ++
 rtl/bitstream_decoder_if.sv | 31 +++
 rtl/bitstream_decoder_ones_counter.sv | 24 ++
 rtl/bitstream_decoder.sv | 109 ++++++++++
 tb/tb_bitstream_decoder.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/bitstream_decoder_pkg.sv
// Shared types and helpers for the stochastic bitstream decoder.
// The state enum, the exponent-width function and the window-exponent clamp
// live here so that the interface and the top module agree on widths.
package bitstream_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Width needed to hold a window exponent in the range 0..bw
  function automatic int calc_logw(input int bw);
    return $clog2(bw + 1);
  endfunction

  // Windows larger than the output resolution are meaningless, so cap k at bw
  function automatic int clamp_k(input int k, input int bw);
    return (k > bw) ? bw : k;
  endfunction

endpackage

// File: rtl/bitstream_decoder_if.sv
// Control, stream and result handshake bundle for bitstream_decoder.
// The master side drives the stream and accepts results; the slave side is the decoder.
interface bitstream_decoder_if
  import bitstream_decoder_pkg::*;
#(
  parameter int BITWIDTH = 8
);

  localparam int LOGW = calc_logw(BITWIDTH);

  logic                iClr;
  logic                iStart;
  logic [LOGW-1:0]     iWinLog;
  logic                iEn;
  logic                iBit;
  logic                oBusy;
  logic                oValid;
  logic                iReady;
  logic [BITWIDTH-1:0] oBin;

  modport master (
    output iClr, iStart, iWinLog, iEn, iBit, iReady,
    input  oBusy, oValid, oBin
  );

  modport slave (
    input  iClr, iStart, iWinLog, iEn, iBit, iReady,
    output oBusy, oValid, oBin
  );

endinterface

// File: rtl/bitstream_decoder_ones_counter.sv
// Qualified up-counter with synchronous clear, module bitstream_ones_counter.
// Used twice by the decoder: once for the ones count and once for the sample count.
module bitstream_ones_counter #(
  parameter int WIDTH = 9
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear beats increment so an abort or a fresh start always begins from zero
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over a window of 2^k qualified bits
// and presents the scaled, saturated count through a valid/ready handshake.
// Optional feature macro: BITSTREAM_DECODER_BIPOLAR_EN selects a two's-complement
// bipolar result by flipping the MSB of the saturated unipolar value.
module bitstream_decoder
  import bitstream_decoder_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input logic               iClk,
  input logic               iRstN,
  bitstream_decoder_if.slave bus
);

  localparam int LOGW = calc_logw(BITWIDTH);
  localparam int CW   = BITWIDTH + 1;
  localparam logic [BITWIDTH-1:0] SIGN_BIT = {1'b1, {(BITWIDTH-1){1'b0}}};

  state_t              state;
  state_t              next_state;
  logic [LOGW-1:0]     k_reg;
  logic [LOGW-1:0]     shift_amt;
  logic [CW-1:0]       ones_cnt;
  logic [CW-1:0]       sample_cnt;
  logic [CW-1:0]       window_len;
  logic [CW-1:0]       ones_final;
  logic [CW-1:0]       scaled_u;
  logic [BITWIDTH-1:0] unipolar;
  logic [BITWIDTH-1:0] result;
  logic [BITWIDTH-1:0] bin_q;
  logic                start_ok;
  logic                sample;
  logic                clr_cnt;
  logic                last_bit;

  assign start_ok = (state == IDLE) && bus.iStart;
  assign sample   = (state == ACCUM) && bus.iEn;
  assign clr_cnt  = bus.iClr || start_ok;

  bitstream_ones_counter #(.WIDTH(CW)) u_ones_cnt (
    .iClk  (iClk),
    .iRstN (iRstN),
    .clr   (clr_cnt),
    .inc   (sample && bus.iBit),
    .count (ones_cnt)
  );

  bitstream_ones_counter #(.WIDTH(CW)) u_sample_cnt (
    .iClk  (iClk),
    .iRstN (iRstN),
    .clr   (clr_cnt),
    .inc   (sample),
    .count (sample_cnt)
  );

  // The edge sampling bit number 2^k closes the window; the final bit has not
  // reached the ones counter yet, so it is folded in before scaling
  assign window_len = CW'(1) << k_reg;
  assign last_bit   = sample && (sample_cnt == (window_len - CW'(1)));
  assign ones_final = ones_cnt + CW'(bus.iBit);
  assign shift_amt  = LOGW'(BITWIDTH) - k_reg;
  assign scaled_u   = ones_final << shift_amt;
  assign unipolar   = scaled_u[BITWIDTH] ? '1 : scaled_u[BITWIDTH-1:0];

`ifdef BITSTREAM_DECODER_BIPOLAR_EN
  assign result = unipolar ^ SIGN_BIT;
`else
  assign result = unipolar;
  logic unused_sign;
  assign unused_sign = ^SIGN_BIT;
`endif

  // State register, latched window exponent and result register
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= IDLE;
      k_reg <= '0;
      bin_q <= '0;
    end else begin
      state <= next_state;
      if (!bus.iClr && start_ok) begin
        k_reg <= LOGW'(clamp_k(int'(bus.iWinLog), BITWIDTH));
      end
      if (!bus.iClr && last_bit) begin
        bin_q <= result;
      end
    end
  end

  // Next-state logic; clear overrides everything, starts only count in IDLE
  always_comb begin
    next_state = state;
    if (bus.iClr) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.iStart) next_state = ACCUM;
        ACCUM:   if (last_bit)   next_state = HOLD;
        HOLD:    if (bus.iReady) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  assign bus.oBusy  = (state == ACCUM);
  assign bus.oValid = (state == HOLD);
  assign bus.oBin   = bin_q;

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed self-checking bench for bitstream_decoder (BITWIDTH=8).
// Expected results are hand-computed unipolar values, converted to bipolar
// when BITSTREAM_DECODER_BIPOLAR_EN is defined.
module tb_bitstream_decoder;
  import bitstream_decoder_pkg::*;

  localparam int BITWIDTH = 8;
  localparam int LOGW     = calc_logw(BITWIDTH);

  logic iClk  = 1'b0;
  logic iRstN = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bitstream_decoder_if #(.BITWIDTH(BITWIDTH)) bus();

  bitstream_decoder #(.BITWIDTH(BITWIDTH)) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .bus   (bus.slave)
  );

  // 10 ns clock
  always #5 iClk = ~iClk;

  function automatic logic [7:0] polar(input logic [7:0] u);
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
    return u ^ 8'h80;
`else
    return u;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic startWindow(input string tag, input int winLog);
    bus.iStart  = 1'b1;
    bus.iWinLog = LOGW'(winLog);
    @(negedge iClk);
    bus.iStart  = 1'b0;
    checkOutput({tag, "_busy_after_start"}, bus.oBusy, 1);
  endtask

  // Drives n qualified bits from a repeating 16-bit pattern; optional stalls drive iBit=1 with iEn=0
  task automatic feedBits(input string tag, input int n, input logic [15:0] pat, input bit stall);
    int q = 0;
    while (q < n) begin
      if (stall && $urandom_range(0, 2) == 0) begin
        bus.iEn  = 1'b0;
        bus.iBit = 1'b1;
      end else begin
        if (q == n - 1) begin
          checkOutput({tag, "_prelast_valid"}, bus.oValid, 0);
          checkOutput({tag, "_prelast_busy"}, bus.oBusy, 1);
        end
        bus.iEn  = 1'b1;
        bus.iBit = pat[q % 16];
        q++;
      end
      @(negedge iClk);
    end
    bus.iEn  = 1'b0;
    bus.iBit = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input int winLog, input int n,
                               input logic [15:0] pat, input bit stall, input logic [7:0] expU);
    startWindow(tag, winLog);
    feedBits(tag, n, pat, stall);
    checkOutput({tag, "_valid"}, bus.oValid, 1);
    checkOutput({tag, "_busy_done"}, bus.oBusy, 0);
    checkOutput({tag, "_bin"}, bus.oBin, polar(expU));
  endtask

  task automatic completeHandshake(input string tag);
    bus.iReady = 1'b1;
    @(negedge iClk);
    bus.iReady = 1'b0;
    checkOutput({tag, "_hs_valid_low"}, bus.oValid, 0);
  endtask

  initial begin
    bus.iClr    = 1'b0;
    bus.iStart  = 1'b0;
    bus.iWinLog = '0;
    bus.iEn     = 1'b0;
    bus.iBit    = 1'b0;
    bus.iReady  = 1'b0;

    repeat (2) @(negedge iClk);
    checkOutput("rst_busy", bus.oBusy, 0);
    checkOutput("rst_valid", bus.oValid, 0);
    checkOutput("rst_bin", bus.oBin, 0);
    iRstN = 1'b1;
    @(negedge iClk);

    applyStimulus("alt_k8", 8, 256, 16'h5555, 1'b0, 8'h80);
    completeHandshake("alt_k8");
    applyStimulus("ones_k8", 8, 256, 16'hFFFF, 1'b0, 8'hFF);
    completeHandshake("ones_k8");
    applyStimulus("zeros_k8", 8, 256, 16'h0000, 1'b0, 8'h00);
    completeHandshake("zeros_k8");
    applyStimulus("clamp_k12", 12, 256, 16'h0001, 1'b0, 8'h10);
    completeHandshake("clamp_k12");
    applyStimulus("ones_k0", 0, 1, 16'hFFFF, 1'b0, 8'hFF);
    completeHandshake("ones_k0");
    applyStimulus("zeros_k0", 0, 1, 16'h0000, 1'b0, 8'h00);
    completeHandshake("zeros_k0");
    applyStimulus("stall_k4", 4, 16, 16'h00FF, 1'b1, 8'h80);
    completeHandshake("stall_k4");

    // Result held through a stalled handshake, with a start pulse that must be ignored
    applyStimulus("five_k4", 4, 16, 16'h001F, 1'b0, 8'h50);
    for (int i = 0; i < 10; i++) begin
      bus.iStart  = (i == 3);
      bus.iWinLog = LOGW'(2);
      @(negedge iClk);
      checkOutput("hold_valid", bus.oValid, 1);
    end
    bus.iStart = 1'b0;
    checkOutput("hold_busy", bus.oBusy, 0);
    checkOutput("hold_bin", bus.oBin, polar(8'h50));

    // Start coincident with the handshake is ignored
    bus.iReady = 1'b1;
    bus.iStart = 1'b1;
    @(negedge iClk);
    bus.iReady = 1'b0;
    bus.iStart = 1'b0;
    checkOutput("hs_start_valid", bus.oValid, 0);
    checkOutput("hs_start_busy", bus.oBusy, 0);

    // Start at the edge right after the handshake is accepted, then aborted by clear
    startWindow("clr", 4);
    repeat (5) begin
      bus.iEn  = 1'b1;
      bus.iBit = 1'b1;
      @(negedge iClk);
    end
    bus.iClr = 1'b1;
    @(negedge iClk);
    bus.iClr = 1'b0;
    checkOutput("clr_busy", bus.oBusy, 0);
    checkOutput("clr_valid", bus.oValid, 0);
    checkOutput("clr_bin_kept", bus.oBin, polar(8'h50));
    repeat (20) @(negedge iClk);
    bus.iEn  = 1'b0;
    bus.iBit = 1'b0;
    checkOutput("clr_stays_idle_valid", bus.oValid, 0);
    checkOutput("clr_stays_idle_bin", bus.oBin, polar(8'h50));

    applyStimulus("two_k4", 4, 16, 16'h0003, 1'b0, 8'h20);
    completeHandshake("two_k4");

    // Asynchronous reset in the middle of a window
    startWindow("rstmid", 8);
    repeat (20) begin
      bus.iEn  = 1'b1;
      bus.iBit = 1'b1;
      @(negedge iClk);
    end
    #2 iRstN = 1'b0;
    #1;
    checkOutput("rstmid_busy", bus.oBusy, 0);
    checkOutput("rstmid_valid", bus.oValid, 0);
    checkOutput("rstmid_bin", bus.oBin, 0);
    bus.iEn  = 1'b0;
    bus.iBit = 1'b0;
    @(negedge iClk);
    iRstN = 1'b1;
    @(negedge iClk);

    applyStimulus("sat_k2", 2, 4, 16'h000F, 1'b0, 8'hFF);
    completeHandshake("sat_k2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
